// File: rtl/pwm_pkg.sv
// Shared types, widths and saturating duty arithmetic for the PWM duty controller.
package pwm_pkg;

    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned PERIOD_W = 24;

    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_e;

    // Add with clamp at DUTY_MAX; the 9-bit sum cannot wrap for 8-bit operands.
    function automatic logic [DUTY_W-1:0] duty_add_sat(input logic [DUTY_W-1:0] duty,
                                                       input logic [DUTY_W-1:0] step);
        logic [DUTY_W:0] sum;
        sum = {1'b0, duty} + {1'b0, step};
        if (sum > {1'b0, DUTY_MAX}) begin
            return DUTY_MAX;
        end
        return sum[DUTY_W-1:0];
    endfunction

    // Subtract with clamp at zero; the extra top bit is the borrow.
    function automatic logic [DUTY_W-1:0] duty_sub_sat(input logic [DUTY_W-1:0] duty,
                                                       input logic [DUTY_W-1:0] step);
        logic [DUTY_W:0] diff;
        diff = {1'b0, duty} - {1'b0, step};
        if (diff[DUTY_W]) begin
            return '0;
        end
        return diff[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus debouncer for one active-low push-button.
// Key_Level is the accepted (debounced) level; Key_Press pulses for one cycle as the
// accepted level falls. A key already held when reset is released produces no press
// until it has been released and pressed again.
module key_debounce
    import pwm_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic Key_In,
    output logic Key_Level,
    output logic Key_Press
);

    localparam int unsigned        CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic [1:0]       settle_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce counter, level flip and arming decision.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        armed_d = armed_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // settle_q[1] marks that sync2_q now reflects the real pin, not the reset value.
        if (settle_q[1] && sync2_q && level_q) begin
            armed_d = 1'b1;
        end
    end

    // Synchroniser, debounce state and post-reset arming.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            level_q  <= 1'b1;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            sync1_q  <= Key_In;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    assign Key_Level = level_q;
    assign Key_Press = armed_q & level_q & ~level_d;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Turns three raw keys into Duty / Count_P for the PWM generator.
// MANUAL steps Duty with Up/Down; RISE/FALL ramp Duty between 0 and 100 autonomously.
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = 1_000_000,
    parameter int unsigned STEP         = 10,
    parameter int unsigned DUTY_INIT    = 50,
    parameter int unsigned BREATHE_TICK = 500_000,
    // 100 * PERIOD_CYC must fit the generator's 24-bit product, so at most 167_772.
    parameter int unsigned PERIOD_CYC   = 50_000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Key_Up,
    input  logic                Key_Down,
    input  logic                Key_Mode,
    output logic [DUTY_W-1:0]   Duty,
    output logic [PERIOD_W-1:0] Count_P,
    output logic                Mode,
    output logic                Duty_Upd
);

    localparam int unsigned       TICK_W    = (BREATHE_TICK > 1) ? $clog2(BREATHE_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BREATHE_TICK - 1);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] INIT_D    = DUTY_W'(DUTY_INIT);

    logic              up_ev, down_ev, mode_ev;
    logic [2:0]        unused_key_level;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_prev_q;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              mode_q, upd_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_up (
        .CLK       (CLK),
        .RST       (RST),
        .Key_In    (Key_Up),
        .Key_Level (unused_key_level[0]),
        .Key_Press (up_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_down (
        .CLK       (CLK),
        .RST       (RST),
        .Key_In    (Key_Down),
        .Key_Level (unused_key_level[1]),
        .Key_Press (down_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
        .CLK       (CLK),
        .RST       (RST),
        .Key_In    (Key_Mode),
        .Key_Level (unused_key_level[2]),
        .Key_Press (mode_ev)
    );

    // Next state, next duty and breathe tick; the tick counter idles at zero in MANUAL.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tick_d  = '0;
        unique case (state_q)
            ST_MANUAL: begin
                if (mode_ev) begin
                    state_d = (duty_q >= DUTY_MAX) ? ST_FALL : ST_RISE;
                end else if (up_ev && !down_ev) begin
                    duty_d = duty_add_sat(duty_q, STEP_D);
                end else if (down_ev && !up_ev) begin
                    duty_d = duty_sub_sat(duty_q, STEP_D);
                end
            end
            ST_RISE: begin
                // A mode press wins over a tick wrap in the same cycle.
                if (mode_ev) begin
                    state_d = ST_MANUAL;
                end else if (tick_q == TICK_LAST) begin
                    duty_d = duty_add_sat(duty_q, 8'd1);
                    if (duty_d == DUTY_MAX) begin
                        state_d = ST_FALL;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_FALL: begin
                if (mode_ev) begin
                    state_d = ST_MANUAL;
                end else if (tick_q == TICK_LAST) begin
                    duty_d = duty_sub_sat(duty_q, 8'd1);
                    if (duty_d == '0) begin
                        state_d = ST_RISE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase
    end

    // State, duty and indicator registers; Duty_Upd compares against last cycle's Duty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_MANUAL;
            duty_q      <= INIT_D;
            tick_q      <= '0;
            mode_q      <= 1'b0;
            duty_prev_q <= INIT_D;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tick_q      <= tick_d;
            mode_q      <= (state_d != ST_MANUAL);
            duty_prev_q <= duty_q;
            upd_q       <= (duty_q != duty_prev_q);
        end
    end

    assign Duty     = duty_q;
    assign Count_P  = PERIOD_W'(PERIOD_CYC);
    assign Mode     = mode_q;
    assign Duty_Upd = upd_q;

endmodule
